// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module : game_pkg
// Brief  : Shared types and default pacing constants for game_pacer.
// Rev    : 1.0
// ============================================================================
package game_pkg;

  typedef enum logic [1:0] {
    PACE_RUN       = 2'd0,
    PACE_HALT_FAIL = 2'd1,
    PACE_HALT_WIN  = 2'd2
  } pace_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int         c_PERIOD_START     = 6_250_000;
  localparam int         c_PERIOD_STEP      = 500_000;
  localparam int         c_PERIOD_MIN       = 1_250_000;
  localparam int         c_APPLES_PER_LEVEL = 4;
  localparam logic [3:0] c_LEVEL_MAX        = 4'd15;
  localparam bcd_digit_t c_BCD_NINE         = 4'd9;

endpackage : game_pkg
`default_nettype wire

// File: rtl/game_pacer_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module : bcd_counter
// Brief  : Two-digit BCD up-counter, saturating at 99, with synchronous clear.
// Rev    : 1.0
// ============================================================================
module bcd_counter
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_value
);

  bcd_digit_t r_tens;
  bcd_digit_t r_ones;
  logic       w_at_max;

  assign w_at_max = (r_tens == c_BCD_NINE) && (r_ones == c_BCD_NINE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_inc && !w_at_max) begin
      if (r_ones == c_BCD_NINE) begin
        r_ones <= '0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign o_value = {r_tens, r_ones};

endmodule : bcd_counter
`default_nettype wire

// File: rtl/game_pacer.sv
`default_nettype none
// ============================================================================
// Module : game_pacer
// Brief  : Phase-toggle pacer with BCD score, level tracking and speed-up.
// Rev    : 1.0
// ============================================================================
module game_pacer
  import game_pkg::*;
#(
  parameter int PW               = 24,
  parameter int PERIOD_START     = c_PERIOD_START,
  parameter int PERIOD_STEP      = c_PERIOD_STEP,
  parameter int PERIOD_MIN       = c_PERIOD_MIN,
  parameter int APPLES_PER_LEVEL = c_APPLES_PER_LEVEL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_restart,
  input  logic       i_eat,
  input  logic       i_failure,
  input  logic       i_success,
  output logic       o_phase,
  output logic [7:0] o_score,
  output logic [3:0] o_level,
  output logic       o_level_up,
  output logic       o_running
);

  localparam logic [PW-1:0] c_START = PW'(PERIOD_START);
  localparam logic [PW-1:0] c_STEP  = PW'(PERIOD_STEP);
  localparam logic [PW-1:0] c_MIN   = PW'(PERIOD_MIN);
  localparam logic [PW-1:0] c_ONE   = PW'(1);
  localparam logic [3:0]    c_APL   = 4'(APPLES_PER_LEVEL);

  pace_state_t   r_state;
  pace_state_t   w_state_next;
  logic          r_phase;
  logic [PW-1:0] r_cnt;
  logic [PW-1:0] r_period;
  logic [3:0]    r_level;
  logic [3:0]    r_apple_cnt;
  logic          r_level_up;
  logic          r_eat_q;

  logic          w_eat_pulse;
  logic [3:0]    w_apple_inc;
  logic          w_apple_wrap;
  logic          w_do_level;
  logic [PW:0]   w_period_dec;
  logic [PW-1:0] w_period_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PACE_RUN: begin
        if (i_failure)      w_state_next = PACE_HALT_FAIL;
        else if (i_success) w_state_next = PACE_HALT_WIN;
      end
      default: w_state_next = r_state;
    endcase
  end

  assign w_eat_pulse  = i_eat & ~r_eat_q;
  assign w_apple_inc  = r_apple_cnt + 4'd1;
  assign w_apple_wrap = (w_apple_inc == c_APL);
  assign w_do_level   = w_eat_pulse & w_apple_wrap & (r_level != c_LEVEL_MAX);

  // Extra bit catches underflow when the step exceeds the current period.
  assign w_period_dec  = {1'b0, r_period} - {1'b0, c_STEP};
  assign w_period_next = (w_period_dec[PW] || (w_period_dec < {1'b0, c_MIN}))
                         ? c_MIN : w_period_dec[PW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PACE_RUN;
      r_phase     <= 1'b0;
      r_cnt       <= c_START - c_ONE;
      r_period    <= c_START;
      r_level     <= '0;
      r_apple_cnt <= '0;
      r_level_up  <= 1'b0;
      r_eat_q     <= 1'b0;
    end else if (i_restart) begin
      r_state     <= PACE_RUN;
      r_phase     <= 1'b0;
      r_cnt       <= c_START - c_ONE;
      r_period    <= c_START;
      r_level     <= '0;
      r_apple_cnt <= '0;
      r_level_up  <= 1'b0;
      r_eat_q     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_eat_q    <= i_eat;
      r_level_up <= w_do_level;

      if (r_state == PACE_RUN) begin
        if (r_cnt == '0) begin
          r_phase <= ~r_phase;
          r_cnt   <= r_period - c_ONE;
        end else begin
          r_cnt <= r_cnt - c_ONE;
        end
      end

      if (w_eat_pulse) begin
        r_apple_cnt <= w_apple_wrap ? 4'd0 : w_apple_inc;
      end

      if (w_do_level) begin
        r_level  <= r_level + 4'd1;
        r_period <= w_period_next;
      end
    end
  end

  bcd_counter u_score (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (i_restart),
    .i_inc   (w_eat_pulse),
    .o_value (o_score)
  );

  assign o_phase    = r_phase;
  assign o_level    = r_level;
  assign o_level_up = r_level_up;
  assign o_running  = (r_state == PACE_RUN);

endmodule : game_pacer
`default_nettype wire
